// File: rtl/dpram_stream_fifo.sv
// -----------------------------------------------------------------------------
// dpram_stream_fifo
//
// Single-clock streaming FIFO controller that sits in front of an external
// dual-port RAM (16-bit x 512, registered read). RAM port A is the write
// side and port B is the read side. A 2-entry output queue hides the RAM's
// one-cycle read latency, so the FIFO can stream one word per cycle.
//
// Ports
//   clk        single clock (also clocks both RAM ports)
//   reset      asynchronous, active-high reset
//   flush      synchronous clear of all FIFO state
//   in_data    write word               in_valid / in_ready   input handshake
//   out_data   head word                out_valid / out_ready output handshake
//   level      total words held (RAM + read in flight + output queue)
//   a_*        RAM port A (write side): ce, we, addr, write data, byte selects
//   b_*        RAM port B (read side):  ce, we, addr, write data, byte selects
//   b_read     RAM port B read data, valid one cycle after b_ce
// -----------------------------------------------------------------------------
module dpram_stream_fifo #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_W+1:0]     level,
    output logic                  a_ce,
    output logic                  a_we,
    output logic [ADDR_W-1:0]     a_addr,
    output logic [DATA_W-1:0]     a_write,
    output logic [DATA_W/8-1:0]   a_sel,
    output logic                  b_ce,
    output logic                  b_we,
    output logic [ADDR_W-1:0]     b_addr,
    output logic [DATA_W-1:0]     b_write,
    output logic [DATA_W/8-1:0]   b_sel,
    input  logic [DATA_W-1:0]     b_read
);

    // ram_cnt equal to the RAM depth means every RAM word is occupied.
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    // Pointers carry one extra wrap bit so full and empty stay distinct.
    logic [ADDR_W:0]   wptr_q, wptr_d;
    logic [ADDR_W:0]   rptr_q, rptr_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        qcnt_q, qcnt_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;

    logic [ADDR_W:0]   ram_cnt;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              issue;
    logic [2:0]        slots_used;

    assign ram_cnt = wptr_q - rptr_q;
    assign full    = (ram_cnt == DEPTH);
    assign empty   = (ram_cnt == '0);

    assign in_ready  = !full && !reset;
    assign out_valid = (qcnt_q != 2'd0);
    assign out_data  = head_q;

    // flush suppresses every transfer in its cycle.
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    // Queue slots committed after this cycle: held words plus the word
    // arriving from the RAM, minus the one leaving. A new read may only be
    // issued when its result is guaranteed a free slot on arrival.
    assign slots_used = {1'b0, qcnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue      = !empty && (slots_used < 3'd2) && !flush;

    assign level = {1'b0, ram_cnt}
                 + {{(ADDR_W+1){1'b0}}, inflight_q}
                 + {{ADDR_W{1'b0}}, qcnt_q};

    // RAM port A: write side
    assign a_ce    = push;
    assign a_we    = push;
    assign a_addr  = wptr_q[ADDR_W-1:0];
    assign a_write = in_data;
    assign a_sel   = '1;

    // RAM port B: read side
    assign b_ce    = issue;
    assign b_we    = 1'b0;
    assign b_addr  = rptr_q[ADDR_W-1:0];
    assign b_write = '0;
    assign b_sel   = '1;

    always_comb begin
        wptr_d     = wptr_q + {{ADDR_W{1'b0}}, push};
        rptr_d     = rptr_q + {{ADDR_W{1'b0}}, issue};
        inflight_d = issue;
        head_d     = head_q;
        tail_d     = tail_q;
        qcnt_d     = qcnt_q;

        // {capture, pop}: head is always the oldest word, tail the next one.
        unique case ({inflight_q, pop})
            2'b10: begin
                if (qcnt_q == 2'd0) begin
                    head_d = b_read;
                end else begin
                    tail_d = b_read;
                end
                qcnt_d = qcnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                qcnt_d = qcnt_q - 2'd1;
            end
            2'b11: begin
                if (qcnt_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = b_read;
                end else begin
                    head_d = b_read;
                end
            end
            default: begin
            end
        endcase

        // Dropping inflight discards any RAM read still on its way back.
        if (flush) begin
            wptr_d     = '0;
            rptr_d     = '0;
            inflight_d = 1'b0;
            qcnt_d     = 2'd0;
            head_d     = '0;
            tail_d     = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            inflight_q <= 1'b0;
            qcnt_q     <= 2'd0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            inflight_q <= inflight_d;
            qcnt_q     <= qcnt_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

endmodule

// File: tb/tb_dpram_stream_fifo.sv
// -----------------------------------------------------------------------------
// tb_dpram_stream_fifo
//
// Drives dpram_stream_fifo against a behavioural model of the 16 x 512
// registered-read dual-port RAM. Reference model: a queue of accepted words;
// level must equal the queue size and the head must match the queue front.
// -----------------------------------------------------------------------------
module tb_dpram_stream_fifo;

    localparam int AW = 9;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic [AW+1:0] level;
    logic          a_ce, a_we, b_ce, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_write, b_write, b_read;
    logic [DW/8-1:0] a_sel, b_sel;

    dpram_stream_fifo #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level),
        .a_ce(a_ce), .a_we(a_we), .a_addr(a_addr), .a_write(a_write), .a_sel(a_sel),
        .b_ce(b_ce), .b_we(b_we), .b_addr(b_addr), .b_write(b_write), .b_sel(b_sel),
        .b_read(b_read)
    );

    always #5 clk = ~clk;

    // Dual-port RAM with registered read on port B.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (a_ce && a_we) begin
            for (int k = 0; k < DW/8; k++)
                if (a_sel[k]) mem[a_addr][k*8 +: 8] <= a_write[k*8 +: 8];
        end
        if (b_ce && !b_we) b_read <= mem[b_addr];
    end

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    logic [DW-1:0] model_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Apply inputs just after the falling edge and let them settle.
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        #1;
    endtask

    // Compare against the model, advance the model by one cycle, clock.
    task automatic tick();
        bit acc, take;
        check_eq("level", 32'(level), 32'(model_q.size()));
        if (model_q.size() < (1 << AW)) check_eq("in_ready_free", 32'(in_ready), 32'd1);
        if (model_q.size() >= (1 << AW) + 2) check_eq("in_ready_full", 32'(in_ready), 32'd0);
        if (model_q.size() == 0) check_eq("vld_when_empty", 32'(out_valid), 32'd0);
        else if (out_valid) check_eq("dout", 32'(out_data), 32'(model_q[0]));
        acc  = in_valid && in_ready && !flush;
        take = out_valid && out_ready && !flush;
        if (flush) begin
            model_q.delete();
        end else begin
            if (take && model_q.size() > 0) void'(model_q.pop_front());
            if (acc) model_q.push_back(in_data);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, got, first, acc_n;
        bit saw_full;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_level", 32'(level), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // ---- 1: single word latency ----
        drive(1, 16'h1234, 0, 0);
        check_eq("t1_in_ready", 32'(in_ready), 32'd1);
        tick();
        drive(0, 16'h0, 0, 0);
        check_eq("t1_vld_t1", 32'(out_valid), 32'd0);
        tick();
        drive(0, 16'h0, 0, 0);
        check_eq("t1_vld_t2", 32'(out_valid), 32'd0);
        tick();
        drive(0, 16'h0, 1, 0);
        check_eq("t1_vld_t3", 32'(out_valid), 32'd1);
        check_eq("t1_data", 32'(out_data), 32'h1234);
        check_eq("t1_level", 32'(level), 32'd1);
        tick();
        drive(0, 16'h0, 1, 0);
        check_eq("t1_level_after", 32'(level), 32'd0);
        tick();

        // ---- 2: full-rate stream ----
        sent = 0; got = 0; first = -1;
        for (int c = 0; c < 1300 && got < 1000; c++) begin
            drive(sent < 1000, 16'(sent), 1, 0);
            if (first >= 0) check_eq("t2_nogap", 32'(out_valid), 32'd1);
            if (out_valid) begin
                check_eq("t2_data", 32'(out_data), 32'(got));
                got++;
                if (first < 0) first = c;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        check_eq("t2_count", 32'(got), 32'd1000);
        check_eq("t2_first_lat", 32'(first), 32'd3);

        // ---- 3: fill to full, then drain ----
        acc_n = 0;
        for (int c = 0; c < 700; c++) begin
            drive(1, 16'(32'h4000 + acc_n), 0, 0);
            if (!in_ready) break;
            acc_n++;
            tick();
        end
        check_eq("t3_accepted", 32'(acc_n), 32'd514);
        check_eq("t3_level", 32'(level), 32'd514);
        tick();
        tick();
        got = 0;
        for (int c = 0; c < 700 && got < 514; c++) begin
            drive(0, 16'h0, 1, 0);
            if (out_valid) begin
                check_eq("t3_data", 32'(out_data), 32'h4000 + 32'(got));
                got++;
            end
            tick();
        end
        check_eq("t3_drained", 32'(got), 32'd514);
        drive(0, 16'h0, 0, 0);
        check_eq("t3_level_end", 32'(level), 32'd0);

        // ---- 4: random traffic ----
        sent = 0; saw_full = 0;
        for (int c = 0; c < 40000 && (sent < 5000 || model_q.size() > 0); c++) begin
            int ph, pin, pout;
            ph   = (c / 1200) % 3;
            pin  = (ph == 0) ? 90 : (ph == 1) ? 30 : 70;
            pout = (ph == 0) ? 30 : (ph == 1) ? 90 : 70;
            drive((sent < 5000) && ($urandom_range(0, 99) < pin), 16'($urandom),
                  ($urandom_range(0, 99) < pout), 0);
            check_eq("t4_level_max", 32'(level > 514), 32'd0);
            if (model_q.size() == 514) saw_full = 1;
            if (in_valid && in_ready) sent++;
            tick();
        end
        check_eq("t4_sent", 32'(sent), 32'd5000);
        check_eq("t4_empty", 32'(model_q.size()), 32'd0);
        check_eq("t4_saw_full", 32'(saw_full), 32'd1);

        // ---- 5: flush with a read in flight ----
        acc_n = 0;
        for (int c = 0; c < 400 && acc_n < 300; c++) begin
            drive(1, 16'(32'h5000 + acc_n), 0, 0);
            if (in_ready) acc_n++;
            tick();
        end
        drive(1, 16'h5FFF, 1, 0);
        check_eq("t5_issue", 32'(b_ce), 32'd1);
        tick();
        drive(1, 16'hAAAA, 1, 1);
        check_eq("t5_level_pre", 32'(level), 32'd300);
        check_eq("t5_no_push", 32'(a_ce), 32'd0);
        check_eq("t5_no_issue", 32'(b_ce), 32'd0);
        tick();
        drive(0, 16'h0, 0, 0);
        check_eq("t5_vld_after", 32'(out_valid), 32'd0);
        check_eq("t5_level_after", 32'(level), 32'd0);
        check_eq("t5_ready_after", 32'(in_ready), 32'd1);
        tick();
        drive(1, 16'hBEEF, 0, 0);
        tick();
        drive(0, 16'h0, 0, 0);
        check_eq("t5_vld_c1", 32'(out_valid), 32'd0);
        tick();
        drive(0, 16'h0, 0, 0);
        check_eq("t5_vld_c2", 32'(out_valid), 32'd0);
        tick();
        drive(0, 16'h0, 1, 0);
        check_eq("t5_vld_c3", 32'(out_valid), 32'd1);
        check_eq("t5_data", 32'(out_data), 32'hBEEF);
        tick();
        for (int c = 0; c < 6; c++) begin
            drive(0, 16'h0, 1, 0);
            check_eq("t5_alone", 32'(out_valid), 32'd0);
            tick();
        end

        // ---- 6: asynchronous reset mid-stream ----
        for (int c = 0; c < 20; c++) begin
            drive(1, 16'(32'h7000 + c), 1, 0);
            tick();
        end
        #2;
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        check_eq("t6_vld", 32'(out_valid), 32'd0);
        check_eq("t6_level", 32'(level), 32'd0);
        check_eq("t6_in_ready", 32'(in_ready), 32'd0);
        check_eq("t6_out_data", 32'(out_data), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_q.delete();
        sent = 0; got = 0;
        for (int c = 0; c < 200 && got < 50; c++) begin
            drive(sent < 50, 16'(sent), 1, 0);
            if (c == 0) check_eq("t6_ready_release", 32'(in_ready), 32'd1);
            if (out_valid) begin
                check_eq("t6_data", 32'(out_data), 32'(got));
                got++;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        check_eq("t6_count", 32'(got), 32'd50);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
